dot_acc: RTL and testbench



---
 rtl/dot_acc.sv | 131 +++++++++++++
 tb/tb_dot_acc.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dot_acc.sv
// Multiply-accumulate stage: streams 4-bit operand pairs through a 4x4 array
// multiplier and emits the saturated dot product of every LEN pairs.

module mul (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] prod
);
    logic [7:0] pp [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_row
            assign pp[gi] = {4'd0, x & {4{y[gi]}}} << gi;
        end
    endgenerate

    always_comb begin
        prod = 8'd0;
        for (int i = 0; i < 4; i++) begin
            prod = prod + pp[i];
        end
    end
endmodule

module dot_acc #(
    parameter int LEN   = 4,
    parameter int ACC_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       x,
    input  logic [3:0]       y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

    typedef enum logic {ACC, HOLD} state_t;

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic               sat_reg, sat_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [ACC_W-1:0]   sum_reg, sum_next;
    logic               ovf_reg, ovf_next;
    logic               valid_reg, valid_next;

    logic [7:0]         prod;
    logic [ACC_W:0]     nxt_wide;
    logic [ACC_W-1:0]   nxt;
    logic               nxt_ovf;
    logic               accept;

    mul u_mul (
        .x    (x),
        .y    (y),
        .prod (prod)
    );

    // One extra bit catches the carry out so the sum can clamp instead of wrapping.
    assign nxt_wide = {1'b0, acc_reg} + {{(ACC_W - 7){1'b0}}, prod};
    assign nxt      = nxt_wide[ACC_W] ? {ACC_W{1'b1}} : nxt_wide[ACC_W-1:0];
    assign nxt_ovf  = nxt_wide[ACC_W] | sat_reg;

    assign in_ready  = (state_reg == ACC) & ~rst;
    assign accept    = in_valid & in_ready;
    assign out_valid = valid_reg;
    assign out_sum   = sum_reg;
    assign out_ovf   = ovf_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ACC;
            acc_reg   <= '0;
            sat_reg   <= 1'b0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            ovf_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            sat_reg   <= sat_next;
            cnt_reg   <= cnt_next;
            sum_reg   <= sum_next;
            ovf_reg   <= ovf_next;
            valid_reg <= valid_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        sat_next   = sat_reg;
        cnt_next   = cnt_reg;
        sum_next   = sum_reg;
        ovf_next   = ovf_reg;
        valid_next = valid_reg;
        case (state_reg)
            ACC: begin
                if (accept) begin
                    if (cnt_reg == CNT_W'(LEN - 1)) begin
                        sum_next   = nxt;
                        ovf_next   = nxt_ovf;
                        valid_next = 1'b1;
                        acc_next   = '0;
                        sat_next   = 1'b0;
                        cnt_next   = '0;
                        state_next = HOLD;
                    end else begin
                        acc_next = nxt;
                        sat_next = nxt_ovf;
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                // Result registers keep their value after the handshake.
                if (out_ready) begin
                    valid_next = 1'b0;
                    state_next = ACC;
                end
            end
            default: state_next = ACC;
        endcase
    end
endmodule

// File: tb/tb_dot_acc.sv
// Directed/randomised bench for dot_acc: three instances (default, 9-bit
// accumulator, LEN=1) checked against a plain-arithmetic dot-product model.

module tb_dot_acc;
    logic             clk;
    logic             rst;
    logic [2:0]       in_valid;
    logic [2:0]       in_ready;
    logic [2:0][3:0]  x;
    logic [2:0][3:0]  y;
    logic [2:0]       out_valid;
    logic [2:0]       out_ready;
    logic [2:0]       out_ovf;
    logic [9:0]       sum0;
    logic [8:0]       sum1;
    logic [9:0]       sum2;

    int checks = 0;
    int errors = 0;

    dot_acc #(.LEN(4), .ACC_W(10)) u_def (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .x(x[0]), .y(y[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum(sum0), .out_ovf(out_ovf[0])
    );

    dot_acc #(.LEN(4), .ACC_W(9)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .x(x[1]), .y(y[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum(sum1), .out_ovf(out_ovf[1])
    );

    dot_acc #(.LEN(1), .ACC_W(10)) u_one (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .x(x[2]), .y(y[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_sum(sum2), .out_ovf(out_ovf[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sum_of(input int d);
        if (d == 0) return int'(sum0);
        if (d == 1) return int'(sum1);
        return int'(sum2);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Presents one pair after an optional bubble gap and returns #1 after the accepting edge.
    task automatic push(input int d, input logic [3:0] a, input logic [3:0] b, input int gap);
        int t;
        in_valid[d] = 1'b0;
        out_ready[d] = 1'($urandom_range(0, 1));
        repeat (gap) begin
            @(posedge clk); #1;
        end
        x[d] = a;
        y[d] = b;
        in_valid[d] = 1'b1;
        t = 0;
        while (!in_ready[d] && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk("ready_timeout", int'(t < 20), 1);
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        x[d] = $urandom_range(0, 15);
        y[d] = $urandom_range(0, 15);
    endtask

    task automatic run_vec(input int d, input int len, input int w,
                           input logic [3:0] xs[4], input logic [3:0] ys[4],
                           input int maxgap, input int stall, input string tag);
        int total;
        int exp_sum;
        int exp_ovf;
        total = 0;
        for (int i = 0; i < len; i++) begin
            push(d, xs[i], ys[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
            total += int'(xs[i]) * int'(ys[i]);
            if (i < len - 1) chk({tag, "_early_valid"}, int'(out_valid[d]), 0);
        end
        exp_ovf = (total >= (1 << w)) ? 1 : 0;
        exp_sum = exp_ovf ? (1 << w) - 1 : total;
        out_ready[d] = 1'b0;
        chk({tag, "_valid"}, int'(out_valid[d]), 1);
        chk({tag, "_hold_ready"}, int'(in_ready[d]), 0);
        chk({tag, "_sum"}, sum_of(d), exp_sum);
        chk({tag, "_ovf"}, int'(out_ovf[d]), exp_ovf);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk({tag, "_stall_valid"}, int'(out_valid[d]), 1);
            chk({tag, "_stall_ready"}, int'(in_ready[d]), 0);
            chk({tag, "_stall_sum"}, sum_of(d), exp_sum);
        end
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        chk({tag, "_drop_valid"}, int'(out_valid[d]), 0);
        chk({tag, "_ready_back"}, int'(in_ready[d]), 1);
        chk({tag, "_keep_sum"}, sum_of(d), exp_sum);
        $display("vec %s dut=%0d total=%0d sum=%0d ovf=%0d", tag, d, total, sum_of(d), out_ovf[d]);
    endtask

    initial begin
        logic [3:0] xs[4];
        logic [3:0] ys[4];

        rst = 1'b1;
        in_valid = '0;
        out_ready = '0;
        x = '0;
        y = '0;
        #12;
        for (int d = 0; d < 3; d++) begin
            chk("rst_in_ready", int'(in_ready[d]), 0);
            chk("rst_out_valid", int'(out_valid[d]), 0);
            chk("rst_out_sum", sum_of(d), 0);
            chk("rst_out_ovf", int'(out_ovf[d]), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) chk("post_rst_ready", int'(in_ready[d]), 1);

        run_vec(0, 4, 10, '{1, 2, 15, 0}, '{1, 3, 15, 9}, 0, 0, "basic");
        run_vec(0, 4, 10, '{1, 2, 15, 0}, '{1, 3, 15, 9}, 0, 5, "stall");
        run_vec(0, 4, 10, '{3, 5, 7, 9}, '{4, 6, 8, 10}, 3, 0, "gaps");
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 4; i++) begin
                xs[i] = $urandom_range(0, 15);
                ys[i] = $urandom_range(0, 15);
            end
            run_vec(0, 4, 10, xs, ys, 2, int'($urandom_range(0, 3)), "rand10");
        end

        run_vec(1, 4, 9, '{15, 15, 15, 15}, '{15, 15, 15, 15}, 0, 0, "sat");
        run_vec(1, 4, 9, '{1, 1, 1, 1}, '{1, 1, 1, 1}, 0, 0, "sat_clear");
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 4; i++) begin
                xs[i] = $urandom_range(8, 15);
                ys[i] = $urandom_range(0, 15);
            end
            run_vec(1, 4, 9, xs, ys, 1, 1, "rand9");
        end

        // Partial vector discarded by reset.
        push(0, 15, 15, 0);
        push(0, 15, 15, 0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", int'(out_valid[0]), 0);
        chk("midrst_ready", int'(in_ready[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_vec(0, 4, 10, '{2, 2, 2, 2}, '{2, 2, 2, 2}, 0, 0, "after_rst");

        // Pending result lost when reset hits during HOLD.
        for (int i = 0; i < 4; i++) push(0, 4'(i + 3), 4'd7, 0);
        out_ready[0] = 1'b0;
        chk("holdrst_pre_valid", int'(out_valid[0]), 1);
        chk("holdrst_pre_sum", sum_of(0), 126);
        #2 rst = 1'b1;
        #1;
        chk("holdrst_valid", int'(out_valid[0]), 0);
        chk("holdrst_sum", sum_of(0), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("holdrst_ready", int'(in_ready[0]), 1);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_vec(2, 1, 10, '{4'(a), 0, 0, 0}, '{4'(b), 0, 0, 0}, 0, 0, "len1");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
